// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the ID->EX pipeline register slice.
//   REG_IDX_W / DATA_W : register index and datapath widths
//   id_ex_core_t       : fixed-width part of the ID/EX bundle
//   id_ex_t            : full ID/EX bundle at the default control/immediate widths
//   idx_match()        : index compare used by bypass, hold-refresh and load-use
// Optional build macro: R0_HARDWIRE_EN (index 0 never matches a write).
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int DATA_W      = 32;
    localparam int CTRL_W_DFLT = 16;
    localparam int IMM_W_DFLT  = 32;

    localparam logic [REG_IDX_W-1:0] R0 = 5'd0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;

    typedef struct packed {
        logic     valid;
        data_t    a;
        data_t    b;
        reg_idx_t rs;
        reg_idx_t rt;
        reg_idx_t rw;
        logic     we;
        logic     is_load;
    } id_ex_core_t;

    typedef struct packed {
        id_ex_core_t                core;
        logic [CTRL_W_DFLT-1:0]     ctrl;
        logic [IMM_W_DFLT-1:0]      imm;
    } id_ex_t;

    // True when an enabled producer index equals a consumer index.
    // With a hardwired r0, index 0 never carries a real value to forward.
    function automatic logic idx_match(input logic en, input reg_idx_t prod, input reg_idx_t cons);
        logic m;
        m = en && (prod == cons);
`ifdef R0_HARDWIRE_EN
        m = m && (cons != R0);
`endif
        return m;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the decode-side inputs, register-file/writeback inputs, EX control
// and the registered EX outputs of the ID->EX stage.
//   slave  : the stage itself (consumes id_*/rf_*/wb_*/ex_stall/flush,
//            produces id_stall and ex_*)
//   master : the surrounding pipeline (or a testbench)
// ---------------------------------------------------------------------------
interface id_ex_stage_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DFLT,
    parameter int IMM_W  = IMM_W_DFLT
);
    logic              id_valid;
    reg_idx_t          id_rs;
    reg_idx_t          id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    reg_idx_t          id_rw;
    logic              id_we;
    logic              id_is_load;
    logic [CTRL_W-1:0] id_ctrl;
    logic [IMM_W-1:0]  id_imm;
    data_t             rf_a;
    data_t             rf_b;
    logic              wb_we;
    reg_idx_t          wb_rw;
    data_t             wb_w;
    logic              ex_stall;
    logic              flush;

    logic              id_stall;
    logic              ex_valid;
    data_t             ex_a;
    data_t             ex_b;
    reg_idx_t          ex_rs;
    reg_idx_t          ex_rt;
    reg_idx_t          ex_rw;
    logic              ex_we;
    logic              ex_is_load;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [IMM_W-1:0]  ex_imm;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rw, id_we,
               id_is_load, id_ctrl, id_imm, rf_a, rf_b, wb_we, wb_rw, wb_w,
               ex_stall, flush,
        input  id_stall, ex_valid, ex_a, ex_b, ex_rs, ex_rt, ex_rw, ex_we,
               ex_is_load, ex_ctrl, ex_imm
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rw, id_we,
               id_is_load, id_ctrl, id_imm, rf_a, rf_b, wb_we, wb_rw, wb_w,
               ex_stall, flush,
        output id_stall, ex_valid, ex_a, ex_b, ex_rs, ex_rt, ex_rw, ex_we,
               ex_is_load, ex_ctrl, ex_imm
    );

endinterface

// File: rtl/id_ex_stage_operand_bypass.sv
// ---------------------------------------------------------------------------
// operand_bypass
// Index/data compare-select: returns wb_w when the in-flight writeback targets
// idx, otherwise base. Used for the two decode operands and for refreshing the
// held EX operands while EX is stalled.
//   idx    in  register index being read
//   base   in  value to use when there is no writeback hit
//   wb_we  in  writeback enable
//   wb_rw  in  writeback index
//   wb_w   in  writeback data
//   data   out selected operand
// Optional build macro: R0_HARDWIRE_EN (index 0 always reads as zero).
// ---------------------------------------------------------------------------
module operand_bypass
    import pipe_pkg::*;
(
    input  reg_idx_t idx,
    input  data_t    base,
    input  logic     wb_we,
    input  reg_idx_t wb_rw,
    input  data_t    wb_w,
    output data_t    data
);

    always_comb begin
        data = base;
        if (idx_match(wb_we, wb_rw, idx)) begin
            data = wb_w;
        end
`ifdef R0_HARDWIRE_EN
        if (idx == R0) begin
            data = '0;
        end
`endif
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID->EX pipeline register of the 5-stage MIPS core. Captures both register
// file operands with same-cycle writeback bypass (the register file still
// shows old data while a write is in flight), inserts one bubble on load-use,
// holds under EX stall while refreshing held operands from writeback, and
// kills the entering instruction on flush.
//   clk    in  clock, all state updates on posedge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of id_ex_stage_if:
//          id_* / rf_* / wb_* / ex_stall / flush in, id_stall / ex_* out
// Parameters: CTRL_W (control word width), IMM_W (immediate width); must
// match the connected interface instance.
// Optional build macro: R0_HARDWIRE_EN (register 0 reads as zero, is never
// forwarded/matched, and never written).
// ---------------------------------------------------------------------------
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DFLT,
    parameter int IMM_W  = IMM_W_DFLT
)(
    input  logic        clk,
    input  logic        rst_n,
    id_ex_stage_if.slave bus
);

    id_ex_core_t       ex_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [IMM_W-1:0]  ex_imm_q;

    data_t op_a;
    data_t op_b;
    data_t hold_a;
    data_t hold_b;
    logic  lu;
    logic  we_cap;

    operand_bypass u_byp_a (
        .idx   (bus.id_rs),
        .base  (bus.rf_a),
        .wb_we (bus.wb_we),
        .wb_rw (bus.wb_rw),
        .wb_w  (bus.wb_w),
        .data  (op_a)
    );

    operand_bypass u_byp_b (
        .idx   (bus.id_rt),
        .base  (bus.rf_b),
        .wb_we (bus.wb_we),
        .wb_rw (bus.wb_rw),
        .wb_w  (bus.wb_w),
        .data  (op_b)
    );

    // While EX is held, a writeback to one of its sources would otherwise be
    // lost: the register file has moved on but the held operand has not.
    operand_bypass u_refresh_a (
        .idx   (ex_q.rs),
        .base  (ex_q.a),
        .wb_we (bus.wb_we),
        .wb_rw (bus.wb_rw),
        .wb_w  (bus.wb_w),
        .data  (hold_a)
    );

    operand_bypass u_refresh_b (
        .idx   (ex_q.rt),
        .base  (ex_q.b),
        .wb_we (bus.wb_we),
        .wb_rw (bus.wb_rw),
        .wb_w  (bus.wb_w),
        .data  (hold_b)
    );

    // Load in EX whose destination is read by the decoding instruction.
    always_comb begin
        lu = ex_q.valid & ex_q.is_load & ex_q.we & bus.id_valid &
             (idx_match(bus.id_use_rs, ex_q.rw, bus.id_rs) |
              idx_match(bus.id_use_rt, ex_q.rw, bus.id_rt));
    end

    // Invalid slots never carry a write enable into EX.
    always_comb begin
        we_cap = bus.id_we & bus.id_valid;
`ifdef R0_HARDWIRE_EN
        if (bus.id_rw == R0) begin
            we_cap = 1'b0;
        end
`endif
    end

    // Gated by rst_n so decode is never held while the stage is in reset.
    assign bus.id_stall = rst_n & (bus.ex_stall | (lu & ~bus.flush));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            ex_ctrl_q <= '0;
            ex_imm_q  <= '0;
        end else if (bus.flush) begin
            ex_q      <= '0;
            ex_ctrl_q <= '0;
            ex_imm_q  <= '0;
        end else if (bus.ex_stall) begin
            ex_q.a <= hold_a;
            ex_q.b <= hold_b;
        end else if (lu) begin
            ex_q.valid   <= 1'b0;
            ex_q.we      <= 1'b0;
            ex_q.is_load <= 1'b0;
        end else begin
            ex_q <= '{valid:   bus.id_valid,
                      a:       op_a,
                      b:       op_b,
                      rs:      bus.id_rs,
                      rt:      bus.id_rt,
                      rw:      bus.id_rw,
                      we:      we_cap,
                      is_load: bus.id_is_load};
            ex_ctrl_q <= bus.id_ctrl;
            ex_imm_q  <= bus.id_imm;
        end
    end

    assign bus.ex_valid   = ex_q.valid;
    assign bus.ex_a       = ex_q.a;
    assign bus.ex_b       = ex_q.b;
    assign bus.ex_rs      = ex_q.rs;
    assign bus.ex_rt      = ex_q.rt;
    assign bus.ex_rw      = ex_q.rw;
    assign bus.ex_we      = ex_q.we;
    assign bus.ex_is_load = ex_q.is_load;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.ex_imm     = ex_imm_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and execute of the 5-stage MIPS core.
- Captures the two read operands from the 32x32 register file, which has combinational reads and a posedge write.
- Adds same-cycle writeback bypass, because the register file returns old data while a write is in flight.
- Detects load-use hazards, inserts bubbles, and handles downstream stall and flush.

Parameters:
CTRL_W, 16, width of opaque decoded control word carried ID->EX
IMM_W, 32, width of sign/zero-extended immediate carried ID->EX

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_rs  in  5  source register A index (drives register file rA)
id_rt  in  5  source register B index (drives register file rB)
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_rw  in  5  destination register index
id_we  in  1  instruction writes register file
id_is_load  in  1  instruction is a load
id_ctrl  in  CTRL_W  decoded control word
id_imm  in  IMM_W  extended immediate
rf_a  in  32  register file output A
rf_b  in  32  register file output B
wb_we  in  1  writeback enable (same signal as register file WE)
wb_rw  in  5  writeback index (same as register file rW)
wb_w  in  32  writeback data (same as register file w)
ex_stall  in  1  EX cannot accept; hold this stage
flush  in  1  kill the instruction entering EX (branch/jump redirect)
id_stall  out  1  decode must hold its instruction this cycle
ex_valid  out  1  EX slot valid
ex_a  out  32  operand A
ex_b  out  32  operand B
ex_rs, ex_rt, ex_rw  out  5 each  indices carried to EX (for the forwarding unit)
ex_we, ex_is_load  out  1 each
ex_ctrl  out  CTRL_W
ex_imm  out  IMM_W

Behaviour:
- Reset (rst_n low, async): all ex_* outputs are 0, including ex_valid=0. id_stall is combinational; during reset it is 0.
- Bypass (combinational):
  - op_a = (wb_we && wb_rw==id_rs) ? wb_w : rf_a
  - op_b = (wb_we && wb_rw==id_rt) ? wb_w : rf_b
- Load-use:
  - lu = ex_valid & ex_is_load & ex_we & id_valid & ((id_use_rs & ex_rw==id_rs) | (id_use_rt & ex_rw==id_rt))
- id_stall = ex_stall | (lu & ~flush).
- Posedge update, first matching rule wins:
  1. flush: ex_valid<=0; other fields don't-care (zeroed). Applies even if ex_stall=1.
  2. ex_stall: all fields hold, with hold-refresh:
     - if wb_we && wb_rw==ex_rs, then ex_a<=wb_w
     - if wb_we && wb_rw==ex_rt, then ex_b<=wb_w
  3. lu: bubble; ex_valid<=0, ex_we<=0, ex_is_load<=0. Decode holds, so the stalled instruction re-presents next cycle and captures then.
  4. Otherwise: capture ex_valid<=id_valid, ex_a<=op_a, ex_b<=op_b, and all other id_* fields into ex_*.
- Latency: 1 cycle ID->EX. Load-use costs exactly one bubble.
- Bubble/invalid slots always present ex_we=0.
- Reset released mid-stream: the first capture occurs on the first posedge with rst_n high.

Optional Feature:
- Macro: R0_HARDWIRE_EN.
- Defined:
  - Index 0 reads as 0: op_a=0 when id_rs==0, op_b=0 when id_rt==0.
  - Bypass, hold-refresh and load-use matching all ignore index 0.
  - ex_we forced to 0 when id_rw==0.
- Undefined: register 0 is an ordinary writable register, matching the current register file; no special-casing.

Decomposition:
- Shared package pipe_pkg:
  - REG_IDX_W=5, DATA_W=32
  - typedef of the ID/EX bundle (valid, a, b, rs, rt, rw, we, is_load, ctrl, imm)
  - localparam R0=5'd0
- One natural sub-module, operand_bypass: index/data compare-select, instantiated once per operand and reused for hold-refresh.
- Load-use detection stays inline.

Test Plan:
- Reset: rst_n=0 mid-capture -> ex_valid=0, ex_a=0, id_stall=0 immediately, without waiting for a clock edge.
- WB bypass: rf_a=0x11, wb_we=1, wb_rw=id_rs=5, wb_w=0xDEAD -> ex_a=0xDEAD next cycle; ex_b=rf_b.
- Load-use: lw r7 in EX, then add with id_rs=7 and id_use_rs=1 -> id_stall=1 for one cycle, one bubble (ex_valid=0, ex_we=0), then the add captures. Same case with id_use_rs=0 -> no stall.
- Hold-refresh: ex_stall=1 for 3 cycles with ex_rs=4; wb writes r4=0x1234 in cycle 2 -> ex_a=0x1234 on release; other fields unchanged.
- Flush beats stall: flush=1 with ex_stall=1 and lu=1 -> ex_valid=0, id_stall=1 (from ex_stall).
- R0_HARDWIRE_EN: wb_we=1, wb_rw=0, wb_w=0xFFFF, id_rs=0 -> ex_a=0. Without the macro -> ex_a=0xFFFF.
